// File: rtl/lfsr_scan_controller_if.sv
// Handshake and result bundle between the scan controller and its user.
// The master drives start/match; the slave (controller) drives the rest.
interface lfsr_scan_controller_if;
    logic       start;
    logic       match;
    logic [3:0] sel;
    logic       sel_valid;
    logic       busy;
    logic       done;
    logic       hit;
    logic [3:0] hit_addr;
    logic [4:0] hit_cnt;

    modport master (
        output start, match,
        input  sel, sel_valid, busy, done, hit, hit_addr, hit_cnt
    );

    modport slave (
        input  start, match,
        output sel, sel_valid, busy, done, hit, hit_addr, hit_cnt
    );
endinterface

// File: rtl/lfsr_scan_controller.sv
// Sweeps 16 decoder select codes (0000, then LFSR x^4+x^3+1) and tallies matches.
// Define SCAN_EARLY_STOP_EN to end the sweep at the first matching code.
module lfsr_scan_controller #(
    parameter int unsigned DWELL = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    lfsr_scan_controller_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        ZERO,
        SCAN,
        DONE
    } state_t;

    localparam logic [3:0] LAST_DWELL = 4'(DWELL - 1);
    localparam logic [3:0] LAST_CODE  = 4'b1000;

    state_t     r_state;
    logic [3:0] r_dwell;
    logic [3:0] r_sel;
    logic       r_sel_valid;
    logic       r_busy;
    logic       r_done;
    logic       r_hit;
    logic [3:0] r_hit_addr;
    logic [4:0] r_hit_cnt;

    logic       w_last;
    logic       w_stop_early;
    logic       w_end;
    logic [3:0] w_next;

    assign w_last = (r_dwell == LAST_DWELL);
    assign w_next = {r_sel[2:0], r_sel[3] ^ r_sel[2]};

`ifdef SCAN_EARLY_STOP_EN
    assign w_stop_early = bus.match;
`else
    assign w_stop_early = 1'b0;
`endif

    // Sweep ends on the sample of the final LFSR code, or early on a hit.
    assign w_end = w_last &
        (w_stop_early | (r_state == SCAN && r_sel == LAST_CODE));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_dwell     <= '0;
            r_sel       <= '0;
            r_sel_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_hit       <= 1'b0;
            r_hit_addr  <= '0;
            r_hit_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_state     <= ZERO;
                        r_dwell     <= '0;
                        r_sel       <= '0;
                        r_sel_valid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_hit       <= 1'b0;
                        r_hit_addr  <= '0;
                        r_hit_cnt   <= '0;
                    end
                end
                ZERO, SCAN: begin
                    if (w_last) begin
                        r_dwell <= '0;
                        if (bus.match) begin
                            r_hit_cnt <= r_hit_cnt + 5'd1;
                            if (!r_hit) begin
                                r_hit      <= 1'b1;
                                r_hit_addr <= r_sel;
                            end
                        end
                        if (w_end) begin
                            r_state     <= DONE;
                            r_sel       <= '0;
                            r_sel_valid <= 1'b0;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                        end else if (r_state == ZERO) begin
                            r_state <= SCAN;
                            r_sel   <= 4'b0001;
                        end else begin
                            r_sel <= w_next;
                        end
                    end else begin
                        r_dwell <= r_dwell + 4'd1;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.sel       = r_sel;
    assign bus.sel_valid = r_sel_valid;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.hit       = r_hit;
    assign bus.hit_addr  = r_hit_addr;
    assign bus.hit_cnt   = r_hit_cnt;
endmodule
